coeff_bank_loader: RTL and testbench

//  Write side of the piecewise-polynomial coefficient bank. Accepts a host word stream on a valid/ready port,

---
 rtl/coeff_bank_loader.sv | 124 ++++++++++++
 tb/tb_coeff_bank_loader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_bank_loader.sv
// coeff_bank_loader
//   Write side of the piecewise-polynomial coefficient bank. A host streams NUM_COEFF words
//   over a valid/ready port into a shadow buffer; once the section is complete it is copied
//   into the active bank on the next sample_tick, so the coefficient mux never sees a
//   partially written section.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   load_start      pulse: begin loading section load_section (restarts if already busy)
//   load_section    target section, sampled with load_start
//   load_abort      drop the shadow buffer and return to idle
//   s_valid/s_data  coefficient stream; k-th accepted word lands at coefficient index k
//   s_ready         loader accepts a word this cycle
//   sample_tick     safe-commit strobe from the datapath
//   active_bank_o   flat bank; section s, index k at [(s*NUM_COEFF+k)*COEFF_W +: COEFF_W]
//   load_busy       loading or waiting for commit
//   commit_o        high in the cycle whose clock edge updates the active bank
//   err_o           high in the cycle a load_start interrupts a load in progress
module coeff_bank_loader #(
    parameter int unsigned COEFF_W   = 32,
    parameter int unsigned NUM_COEFF = 11,
    parameter int unsigned NUM_SECT  = 4,
    parameter int unsigned SECT_W    = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load_start,
    input  logic [SECT_W-1:0]               load_section,
    input  logic                            load_abort,
    input  logic                            s_valid,
    input  logic [COEFF_W-1:0]              s_data,
    output logic                            s_ready,
    input  logic                            sample_tick,
    output logic [NUM_SECT*NUM_COEFF*COEFF_W-1:0] active_bank_o,
    output logic                            load_busy,
    output logic                            commit_o,
    output logic                            err_o
);

    localparam int unsigned CNT_W    = $clog2(NUM_COEFF);
    localparam int unsigned SHADOW_W = NUM_COEFF * COEFF_W;
    localparam int unsigned BANK_W   = NUM_SECT * SHADOW_W;

    typedef enum logic [1:0] {StIdle, StLoad, StWaitCommit} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [SECT_W-1:0]   sect_q, sect_d;
    logic [SHADOW_W-1:0] shadow_q, shadow_d;
    logic [BANK_W-1:0]   bank_q, bank_d;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        sect_d    = sect_q;
        shadow_d  = shadow_q;
        bank_d    = bank_q;
        s_ready   = 1'b0;
        commit_o  = 1'b0;
        err_o     = 1'b0;
        load_busy = (state_q != StIdle);

        case (state_q)
            StIdle: begin
                // load_abort has nothing to cancel here, so load_start is honoured
                if (load_start) begin
                    state_d  = StLoad;
                    sect_d   = load_section;
                    count_d  = '0;
                    shadow_d = '0;
                end
            end
            StLoad, StWaitCommit: begin
                if (load_abort) begin
                    state_d  = StIdle;
                    count_d  = '0;
                    shadow_d = '0;
                end else if (load_start) begin
                    // Restart with the new section; a word offered this cycle is refused
                    err_o    = 1'b1;
                    state_d  = StLoad;
                    sect_d   = load_section;
                    count_d  = '0;
                    shadow_d = '0;
                end else if (state_q == StLoad) begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        shadow_d[int'(count_q) * COEFF_W +: COEFF_W] = s_data;
                        if (count_q == CNT_W'(NUM_COEFF - 1)) begin
                            // A tick in this same cycle must not commit; wait for the next one
                            count_d = '0;
                            state_d = StWaitCommit;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end else if (sample_tick) begin
                    commit_o = 1'b1;
                    bank_d[int'(sect_q) * SHADOW_W +: SHADOW_W] = shadow_q;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            count_q  <= '0;
            sect_q   <= '0;
            shadow_q <= '0;
            bank_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sect_q   <= sect_d;
            shadow_q <= shadow_d;
            bank_q   <= bank_d;
        end
    end

    assign active_bank_o = bank_q;

endmodule

// File: tb/tb_coeff_bank_loader.sv
// Testbench for coeff_bank_loader: a fixed vector table, directed multi-cycle sequences and a
// randomized run, all checked against a queue-based model of the load/commit protocol.
module tb_coeff_bank_loader;

    localparam int COEFF_W   = 32;
    localparam int NUM_COEFF = 11;
    localparam int NUM_SECT  = 4;
    localparam int SECT_W    = 2;
    localparam int BANK_W    = NUM_SECT * NUM_COEFF * COEFF_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_start;
    logic [SECT_W-1:0] load_section;
    logic              load_abort;
    logic              s_valid;
    logic [COEFF_W-1:0] s_data;
    logic              s_ready;
    logic              sample_tick;
    logic [BANK_W-1:0] active_bank_o;
    logic              load_busy;
    logic              commit_o;
    logic              err_o;

    always #5 clk = ~clk;

    coeff_bank_loader #(
        .COEFF_W  (COEFF_W),
        .NUM_COEFF(NUM_COEFF),
        .NUM_SECT (NUM_SECT),
        .SECT_W   (SECT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .load_section (load_section),
        .load_abort   (load_abort),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .sample_tick  (sample_tick),
        .active_bank_o(active_bank_o),
        .load_busy    (load_busy),
        .commit_o     (commit_o),
        .err_o        (err_o)
    );

    int vec_count  = 0;
    int miscompares = 0;

    // Reference model: a section is "collecting" until its queue holds NUM_COEFF words,
    // then it waits for a tick; the bank is a plain 2-D array.
    bit           m_active;
    logic [1:0]   m_sect;
    logic [31:0]  m_q[$];
    logic [31:0]  m_bank[NUM_SECT][NUM_COEFF];
    logic         e_ready, e_busy, e_commit, e_err;

    typedef struct {
        logic        st;
        logic [1:0]  sect;
        logic        ab;
        logic        v;
        logic [31:0] d;
        logic        t;
        logic        r;
        logic        b;
        logic        c;
        logic        e;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bank_word(input int s, input int k);
        return active_bank_o[(s * NUM_COEFF + k) * COEFF_W +: COEFF_W];
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_sect   = '0;
        m_q.delete();
        for (int s = 0; s < NUM_SECT; s++)
            for (int k = 0; k < NUM_COEFF; k++) m_bank[s][k] = '0;
    endtask

    task automatic model_eval();
        e_ready = 0; e_busy = 0; e_commit = 0; e_err = 0;
        if (!m_active) begin
            if (load_start) begin
                m_active = 1'b1;
                m_sect   = load_section;
                m_q.delete();
            end
        end else begin
            e_busy = 1;
            if (load_abort) begin
                m_active = 1'b0;
                m_q.delete();
            end else if (load_start) begin
                e_err  = 1;
                m_sect = load_section;
                m_q.delete();
            end else if (m_q.size() < NUM_COEFF) begin
                e_ready = 1;
                if (s_valid) m_q.push_back(s_data);
            end else if (sample_tick) begin
                e_commit = 1;
                for (int k = 0; k < NUM_COEFF; k++) m_bank[m_sect][k] = m_q[k];
                m_active = 1'b0;
                m_q.delete();
            end
        end
    endtask

    task automatic check_bank();
        logic [BANK_W-1:0] exp;
        for (int s = 0; s < NUM_SECT; s++)
            for (int k = 0; k < NUM_COEFF; k++)
                exp[(s * NUM_COEFF + k) * COEFF_W +: COEFF_W] = m_bank[s][k];
        vec_count++;
        if (active_bank_o !== exp) begin
            miscompares++;
            for (int i = 0; i < NUM_SECT * NUM_COEFF; i++) begin
                if (active_bank_o[i * COEFF_W +: COEFF_W] !== exp[i * COEFF_W +: COEFF_W]) begin
                    $display("FAIL bank sect %0d idx %0d: got 0x%0h required 0x%0h",
                             i / NUM_COEFF, i % NUM_COEFF, active_bank_o[i * COEFF_W +: COEFF_W],
                             exp[i * COEFF_W +: COEFF_W]);
                    break;
                end
            end
        end
    endtask

    task automatic drive(input logic st, input logic [1:0] sect, input logic ab, input logic v,
                         input logic [31:0] d, input logic t);
        @(negedge clk);
        load_start   = st;
        load_section = sect;
        load_abort   = ab;
        s_valid      = v;
        s_data       = d;
        sample_tick  = t;
    endtask

    task automatic step(input logic st, input logic [1:0] sect, input logic ab, input logic v,
                        input logic [31:0] d, input logic t);
        drive(st, sect, ab, v, d, t);
        #1;
        check_bank();
        model_eval();
        chk("s_ready", s_ready, e_ready);
        chk("load_busy", load_busy, e_busy);
        chk("commit_o", commit_o, e_commit);
        chk("err_o", err_o, e_err);
    endtask

    task automatic idle(input int n, input logic t);
        for (int i = 0; i < n; i++) step(0, 2'd0, 0, 0, 32'h0, t);
    endtask

    task automatic feed_words(input logic [31:0] base, input int n, input int throttle);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 400) begin
            logic v;
            v = ((guard % throttle) == 0);
            step(0, 2'd0, 0, v, base + 32'(k), 0);
            if (v && e_ready) k++;
            guard++;
        end
        if (k < n) begin
            vec_count++;
            miscompares++;
            $display("FAIL feed_words: accepted %0d words, required %0d", k, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        load_start = 0; load_section = 0; load_abort = 0;
        s_valid = 0; s_data = 0; sample_tick = 0;
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_load_busy", load_busy, 0);
        chk("rst_commit", commit_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_bank_zero", |active_bank_o, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        load_start = 0; load_section = 0; load_abort = 0;
        s_valid = 0; s_data = 0; sample_tick = 0;
        model_reset();
        #12;
        do_reset();

        //              st sect ab v  data          t   r  b  c  e
        tbl[0] = '{1'b0, 2'd0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 2'd0, 1'b0, 1'b1, 32'h1234,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 2'd0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 2'd2, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 2'd0, 1'b0, 1'b1, 32'h1,     1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 2'd0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 2'd3, 1'b0, 1'b1, 32'h2,     1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 2'd1, 1'b1, 1'b1, 32'h3,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 2'd0, 1'b0, 1'b1, 32'h4,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].st, tbl[i].sect, tbl[i].ab, tbl[i].v, tbl[i].d, tbl[i].t);
            #1;
            check_bank();
            model_eval();
            chk($sformatf("tbl%0d_s_ready", i), s_ready, tbl[i].r);
            chk($sformatf("tbl%0d_load_busy", i), load_busy, tbl[i].b);
            chk($sformatf("tbl%0d_commit", i), commit_o, tbl[i].c);
            chk($sformatf("tbl%0d_err", i), err_o, tbl[i].e);
        end

        // 1: section 1, tick three cycles after the last word
        do_reset();
        step(1, 2'd1, 0, 0, 32'h0, 0);
        feed_words(32'h100, NUM_COEFF, 1);
        idle(3, 0);
        step(0, 2'd0, 0, 0, 32'h0, 1);
        chk("t1_commit", commit_o, 1);
        idle(2, 0);
        for (int k = 0; k < NUM_COEFF; k++)
            chk($sformatf("t1_sect1_idx%0d", k), bank_word(1, k), 32'h100 + 32'(k));
        chk("t1_sect0_zero", bank_word(0, 0), 0);

        // 2: throttled stream into section 3; tick on the 11th-accept cycle must not commit
        step(1, 2'd3, 0, 0, 32'h0, 0);
        feed_words(32'hA5A5_0000, NUM_COEFF - 1, 3);
        step(0, 2'd0, 0, 1, 32'hA5A5_000A, 1);
        chk("t2_no_commit_on_last", commit_o, 0);
        step(0, 2'd0, 0, 1, 32'hDEAD_BEEF, 0);
        chk("t2_ready_after_11", s_ready, 0);
        step(0, 2'd0, 0, 0, 32'h0, 1);
        chk("t2_commit", commit_o, 1);
        idle(1, 0);
        chk("t2_idx10", bank_word(3, 10), 32'hA5A5_000A);

        // 3: section 0 held waiting for 50 cycles
        step(1, 2'd0, 0, 0, 32'h0, 0);
        feed_words(32'h300, NUM_COEFF, 2);
        idle(50, 0);
        chk("t3_busy_held", load_busy, 1);
        step(0, 2'd0, 0, 0, 32'h0, 1);
        chk("t3_commit", commit_o, 1);

        // 4: restart into section 2 after five words of section 1
        step(1, 2'd1, 0, 0, 32'h0, 0);
        feed_words(32'h400, 5, 1);
        step(1, 2'd2, 0, 1, 32'hBAD0_0000, 0);
        chk("t4_err", err_o, 1);
        feed_words(32'h2000, NUM_COEFF, 1);
        idle(1, 1);
        idle(1, 0);
        chk("t4_sect1_kept", bank_word(1, 4), 32'h104);
        chk("t4_sect2_idx0", bank_word(2, 0), 32'h2000);

        // 5: abort mid-load, then abort in the wait state together with a tick
        step(1, 2'd2, 0, 0, 32'h0, 0);
        feed_words(32'h500, 10, 1);
        step(0, 2'd0, 1, 1, 32'h50A, 0);
        idle(1, 0);
        chk("t5_idle_busy", load_busy, 0);
        step(1, 2'd2, 0, 0, 32'h0, 0);
        feed_words(32'h510, NUM_COEFF, 1);
        idle(2, 0);
        step(0, 2'd0, 1, 0, 32'h0, 1);
        chk("t5_abort_no_commit", commit_o, 0);
        idle(3, 1);
        chk("t5_s_ready_idle", s_ready, 0);
        chk("t5_sect2_kept", bank_word(2, 10), 32'h200A);

        // 6: reset while waiting to commit a freshly loaded section
        step(1, 2'd1, 0, 0, 32'h0, 0);
        feed_words(32'h600, NUM_COEFF, 1);
        idle(2, 0);
        do_reset();
        idle(4, 1);
        chk("t6_bank_cleared", |active_bank_o, 0);

        // Randomized protocol traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 99) < 3, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 65,
                 $urandom, $urandom_range(0, 99) < 20);
        end
        idle(2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
